// File: rtl/conv_encoder_213_pkg.sv
// ============================================================================
// conv_encoder_213_pkg : shared (2,1,3) code parameters, FSM encoding, symbol fn
// Revision: 1.0
// ============================================================================
`default_nettype none

package conv_encoder_213_pkg;

  localparam int ENC_M = 3;
  localparam logic [ENC_M:0] ENC_G0 = 4'b1101;  // octal 15, MSB taps the input
  localparam logic [ENC_M:0] ENC_G1 = 4'b1111;  // octal 17
  localparam int ENC_CNT_W = 16;

  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_DATA = 2'd1;
  localparam logic [ST_W-1:0] ST_TAIL = 2'd2;

  // Branch symbol {G0 parity, G1 parity} for trellis state s and input u.
  function automatic logic [1:0] enc_symbol(input logic [ENC_M-1:0] s, input logic u);
    logic [ENC_M:0] r;
    r = {u, s};
    return {^(r & ENC_G0), ^(r & ENC_G1)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_encoder_213_if.sv
// ============================================================================
// conv_encoder_213_if : bit-in / symbol-out handshake bundle of the encoder
// Revision: 1.0
// ============================================================================
`default_nettype none

interface conv_encoder_213_if
  import conv_encoder_213_pkg::*;
#(
  parameter int CNT_W = ENC_CNT_W
) ();

  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_sym;
  logic             out_tail;
  logic             out_last;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_sym, out_tail, out_last, busy, frame_cnt
  );

  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_sym, out_tail, out_last, busy, frame_cnt
  );

endinterface

`default_nettype wire

// File: rtl/conv_enc_213_core.sv
// ============================================================================
// conv_enc_213_core : combinational trellis step (s, u) -> (sym, next_s)
// Revision: 1.0
// ============================================================================
`default_nettype none

module conv_enc_213_core
  import conv_encoder_213_pkg::*;
#(
  parameter int           M  = ENC_M,
  parameter logic [M:0]   G0 = ENC_G0,
  parameter logic [M:0]   G1 = ENC_G1
) (
  input  logic [M-1:0] s,
  input  logic         u,
  output logic [1:0]   sym,
  output logic [M-1:0] next_s
);

  logic [M:0] r;

  always_comb begin
    r   = {u, s};
    sym = {^(r & G0), ^(r & G1)};
  end

  // New bit enters at the MSB so the state index matches the decoder's numbering.
  if (M > 1) begin : g_shift_wide
    assign next_s = {u, s[M-1:1]};
  end else begin : g_shift_one
    assign next_s = u;
  end

endmodule

`default_nettype wire

// File: rtl/conv_encoder_213.sv
// ============================================================================
// conv_encoder_213 : rate-1/2 K=4 convolutional encoder with zero-tail frames
// Revision: 1.0
// ============================================================================
`default_nettype none

module conv_encoder_213
  import conv_encoder_213_pkg::*;
#(
  parameter int         M     = ENC_M,
  parameter logic [M:0] G0    = ENC_G0,
  parameter logic [M:0] G1    = ENC_G1,
  parameter int         CNT_W = ENC_CNT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  conv_encoder_213_if.slave  bus
);

  localparam int              TC_W    = (M > 1) ? $clog2(M) : 1;
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(M - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [ST_W-1:0]  state_q, state_d;
  logic [M-1:0]     s_q, s_d;
  logic [TC_W-1:0]  tail_cnt_q, tail_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       out_sym_q, out_sym_d;
  logic             out_tail_q, out_tail_d;
  logic             out_last_q, out_last_d;

  logic             load, in_ready, accept, tail_step, tail_done, u;
  logic [1:0]       enc_sym;
  logic [M-1:0]     enc_next;

  conv_enc_213_core #(.M(M), .G0(G0), .G1(G1)) u_core (
    .s      (s_q),
    .u      (u),
    .sym    (enc_sym),
    .next_s (enc_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = bus.in_last ? ST_TAIL : ST_DATA;
      ST_DATA: if (accept && bus.in_last) state_d = ST_TAIL;
      ST_TAIL: if (tail_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The single output stage passes ready through, so a full register that is
  // being drained can be reloaded in the same cycle.
  always_comb begin
    load      = !out_valid_q || bus.out_ready;
    in_ready  = load && (state_q != ST_TAIL);
    accept    = bus.in_valid && in_ready;
    tail_step = load && (state_q == ST_TAIL);
    tail_done = tail_step && (tail_cnt_q == TC_LAST);
    u         = (state_q == ST_TAIL) ? 1'b0 : bus.in_bit;
  end

  always_comb begin
    s_d         = s_q;
    tail_cnt_d  = tail_cnt_q;
    frame_cnt_d = frame_cnt_q;
    out_valid_d = out_valid_q;
    out_sym_d   = out_sym_q;
    out_tail_d  = out_tail_q;
    out_last_d  = out_last_q;
    if (accept || tail_step) begin
      s_d = enc_next;
    end
    if (tail_step) begin
      tail_cnt_d = tail_done ? '0 : tail_cnt_q + 1'b1;
    end
    if (accept) begin
      if (state_q == ST_IDLE) begin
        frame_cnt_d = CNT_W'(1);
      end else if (frame_cnt_q != CNT_MAX) begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
    if (load) begin
      out_valid_d = accept || tail_step;
      out_sym_d   = enc_sym;
      out_tail_d  = tail_step;
      out_last_d  = tail_done;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q         <= '0;
      tail_cnt_q  <= '0;
      frame_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_sym_q   <= 2'b00;
      out_tail_q  <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      s_q         <= s_d;
      tail_cnt_q  <= tail_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      out_tail_q  <= out_tail_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sym   = out_sym_q;
  assign bus.out_tail  = out_tail_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_encoder_213.sv
// ============================================================================
// tb_conv_encoder_213 : directed self-checking bench for conv_encoder_213
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_conv_encoder_213;

  localparam int M = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   gaps;

  always #5 clk = ~clk;

  conv_encoder_213_if #(.CNT_W(16)) bus ();

  conv_encoder_213 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one or more frames and checks every consumed symbol; symbol i of
  // syms is at [2i+:2], tails/lsts give the expected out_tail/out_last flags.
  task automatic run_frame(input string nm, input logic [15:0] bits, input logic [15:0] lasts,
                           input int nbits, input logic [63:0] syms, input logic [31:0] tails,
                           input logic [31:0] lsts, input int nsym, input bit stall,
                           output int gap_cnt);
    int ib = 0;
    int ob = 0;
    int cyc = 0;
    bit held = 1'b0;
    logic [1:0] hsym;
    logic htail, hlast;
    gap_cnt = 0;
    while (ob < nsym && cyc < 400) begin
      @(posedge clk);
      #1;
      bus.in_valid  = (ib < nbits);
      bus.in_bit    = (ib < nbits) ? bits[ib] : 1'b0;
      bus.in_last   = (ib < nbits) ? lasts[ib] : 1'b0;
      bus.out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      #1;
      if (held) begin
        chk({nm, " hold_valid"}, bus.out_valid, 1);
        chk({nm, " hold_sym"}, bus.out_sym, hsym);
        chk({nm, " hold_tail"}, bus.out_tail, htail);
        chk({nm, " hold_last"}, bus.out_last, hlast);
      end
      held = 1'b0;
      if (bus.out_valid && !bus.out_ready) begin
        chk({nm, " stall_in_ready"}, bus.in_ready, 0);
        held  = 1'b1;
        hsym  = bus.out_sym;
        htail = bus.out_tail;
        hlast = bus.out_last;
      end
      if (bus.in_valid && bus.in_ready) ib++;
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("%s sym%0d", nm, ob), bus.out_sym, syms[2*ob +: 2]);
        chk($sformatf("%s tail%0d", nm, ob), bus.out_tail, tails[ob]);
        chk($sformatf("%s last%0d", nm, ob), bus.out_last, lsts[ob]);
        if (ob == 0) chk({nm, " busy_first"}, bus.busy, 1);
        ob++;
      end else if (ob > 0 && !bus.out_valid) begin
        gap_cnt++;
      end
      cyc++;
    end
    chk({nm, " symbol_count"}, ob, nsym);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values while reset is held
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst out_sym", bus.out_sym, 0);
    chk("rst out_tail", bus.out_tail, 0);
    chk("rst out_last", bus.out_last, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst frame_cnt", bus.frame_cnt, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst in_ready", bus.in_ready, 1);

    // Frame 1,0,1,1 -> 11,11,10,11 | tail 10,10,11
    run_frame("f1011", 16'b1101, 16'b1000, 4,
              64'({2'b11, 2'b10, 2'b10, 2'b11, 2'b10, 2'b11, 2'b11}),
              32'b1110000, 32'b1000000, 7, 1'b0, gaps);
    chk("f1011 gaps", gaps, 0);
    chk("f1011 busy_end", bus.busy, 0);
    chk("f1011 frame_cnt", bus.frame_cnt, 4);

    // Single-bit frame: s=100 after the data bit, tail gives 11,01,11
    run_frame("single", 16'b1, 16'b1, 1,
              64'({2'b11, 2'b01, 2'b11, 2'b11}),
              32'b1110, 32'b1000, 4, 1'b0, gaps);
    chk("single busy_end", bus.busy, 0);
    chk("single frame_cnt", bus.frame_cnt, 1);

    // Same 4-bit frame with out_ready pattern 1,0,0,1
    run_frame("stall", 16'b1101, 16'b1000, 4,
              64'({2'b11, 2'b10, 2'b10, 2'b11, 2'b10, 2'b11, 2'b11}),
              32'b1110000, 32'b1000000, 7, 1'b1, gaps);
    chk("stall frame_cnt", bus.frame_cnt, 4);

    // Two back-to-back all-ones frames: 11,00,01,10 | 01,10,11 each
    run_frame("b2b", 16'hFF, 16'b1000_1000, 8,
              64'({2'b11, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b11,
                   2'b11, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b11}),
              32'b11100001110000, 32'b10000001000000, 14, 1'b0, gaps);
    chk("b2b gaps", gaps, 0);
    chk("b2b frame_cnt", bus.frame_cnt, 4);

    // Reset asserted mid-tail, right after tail symbol 1 is presented
    begin
      int ib = 0;
      int cyc = 0;
      logic [3:0] b = 4'b1101;
      bit seen = 1'b0;
      while (!seen && cyc < 40) begin
        @(posedge clk);
        #1;
        bus.in_valid  = (ib < 4);
        bus.in_bit    = (ib < 4) ? b[ib] : 1'b0;
        bus.in_last   = (ib == 3);
        bus.out_ready = 1'b1;
        #1;
        if (bus.in_valid && bus.in_ready) ib++;
        if (bus.out_valid && bus.out_tail) seen = 1'b1;
        cyc++;
      end
      chk("midtail reached", seen, 1);
      chk("midtail busy_before", bus.busy, 1);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("midtail out_valid", bus.out_valid, 0);
      chk("midtail busy", bus.busy, 0);
      chk("midtail frame_cnt", bus.frame_cnt, 0);
      chk("midtail out_tail", bus.out_tail, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
    end

    run_frame("after_rst", 16'b1, 16'b1, 1,
              64'({2'b11, 2'b01, 2'b11, 2'b11}),
              32'b1110, 32'b1000, 4, 1'b0, gaps);
    chk("after_rst frame_cnt", bus.frame_cnt, 1);
    chk("after_rst busy_end", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
